simple_check: RTL and testbench

SIMPLE_CHECK -- requirements
Module: simple_check

---
 rtl/simple_check.sv | 148 ++++++++++++++
 tb/tb_simple_check.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simple_check.sv
`default_nettype none
// ============================================================================
// Module     : simple_check
// Description: Byte-stream message matcher with hunting, resync on mismatch,
//              post-match hold-off and saturating match/error counters.
// Revision   : 1.0 - initial release
// ============================================================================
module simple_check #(
    parameter int          msg_len     = 6,
    parameter logic [63:0] expected    = 64'h00000A0D676E6970,
    parameter int          hold_cycles = 4
) (
    input  logic        _clock,
    input  logic        _reset,
    input  logic [7:0]  _rx_in,
    input  logic        _rx_valid,
    output logic        _rx_ready,
    output logic        _match,
    output logic        _error,
    output logic [15:0] _match_count,
    output logic [15:0] _error_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MATCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic [2:0]  c_last_cursor = 3'(msg_len - 1);
    localparam logic [7:0]  c_hold_load   = 8'(hold_cycles);
    localparam bit          c_use_hold    = (hold_cycles > 0);
    localparam logic [15:0] c_cnt_max     = 16'hFFFF;

    state_t      r_state;
    state_t      w_next_state;
    logic [2:0]  r_cursor;
    logic [2:0]  w_next_cursor;
    logic [7:0]  r_hold_cnt;
    logic [7:0]  w_next_hold;
    logic        r_live;
    logic        r_match;
    logic        r_error;
    logic [15:0] r_match_count;
    logic [15:0] r_error_count;

    logic        w_accept;
    logic        w_match_evt;
    logic        w_error_evt;
    logic [7:0]  w_exp_byte;
    logic [7:0]  w_first_byte;

    // r_live keeps the port closed until the first edge after reset release.
    assign _rx_ready    = r_live && (r_state != S_HOLD);
    assign w_accept     = _rx_valid && _rx_ready;
    assign w_exp_byte   = expected[{r_cursor, 3'b000} +: 8];
    assign w_first_byte = expected[7:0];

    always_comb begin
        w_next_state  = r_state;
        w_next_cursor = r_cursor;
        w_next_hold   = r_hold_cnt;
        w_match_evt   = 1'b0;
        w_error_evt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept && (_rx_in == w_first_byte)) begin
                    w_next_state  = S_MATCH;
                    w_next_cursor = 3'd1;
                end
            end
            S_MATCH: begin
                if (w_accept) begin
                    if (_rx_in == w_exp_byte) begin
                        if (r_cursor == c_last_cursor) begin
                            w_match_evt   = 1'b1;
                            w_next_cursor = 3'd0;
                            if (c_use_hold) begin
                                w_next_state = S_HOLD;
                                w_next_hold  = c_hold_load;
                            end else begin
                                w_next_state = S_IDLE;
                            end
                        end else begin
                            w_next_cursor = r_cursor + 3'd1;
                        end
                    end else begin
                        w_error_evt = 1'b1;
                        // A mismatching byte may itself start a new message.
                        if (_rx_in == w_first_byte) begin
                            w_next_state  = S_MATCH;
                            w_next_cursor = 3'd1;
                        end else begin
                            w_next_state  = S_IDLE;
                            w_next_cursor = 3'd0;
                        end
                    end
                end
            end
            S_HOLD: begin
                if (r_hold_cnt <= 8'd1) begin
                    w_next_state = S_IDLE;
                    w_next_hold  = 8'd0;
                end else begin
                    w_next_hold  = r_hold_cnt - 8'd1;
                end
            end
            default: begin
                w_next_state  = S_IDLE;
                w_next_cursor = 3'd0;
                w_next_hold   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge _clock or posedge _reset) begin
        if (_reset) begin
            r_state       <= S_IDLE;
            r_cursor      <= 3'd0;
            r_hold_cnt    <= 8'd0;
            r_live        <= 1'b0;
            r_match       <= 1'b0;
            r_error       <= 1'b0;
            r_match_count <= 16'd0;
            r_error_count <= 16'd0;
        end else begin
            r_state    <= w_next_state;
            r_cursor   <= w_next_cursor;
            r_hold_cnt <= w_next_hold;
            r_live     <= 1'b1;
            r_match    <= w_match_evt;
            r_error    <= w_error_evt;
            if (w_match_evt && (r_match_count != c_cnt_max)) begin
                r_match_count <= r_match_count + 16'd1;
            end
            if (w_error_evt && (r_error_count != c_cnt_max)) begin
                r_error_count <= r_error_count + 16'd1;
            end
        end
    end

    assign _match       = r_match;
    assign _error       = r_error;
    assign _match_count = r_match_count;
    assign _error_count = r_error_count;

endmodule
`default_nettype wire

// File: tb/tb_simple_check.sv
`default_nettype none
// ============================================================================
// Module     : tb_simple_check
// Description: Self-checking bench for simple_check with a message-level model.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_simple_check;

    localparam int          MSG_LEN = 6;
    localparam logic [63:0] EXP     = 64'h00000A0D676E6970;
    localparam int          HOLD    = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rx_in = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rdy;
    logic        mtc;
    logic        err;
    logic [15:0] mcnt;
    logic [15:0] ecnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: message progress, remaining hold-off, event flags, counts.
    int m_pos, m_hold, m_mcount, m_ecount;
    bit m_live, m_match, m_error;

    simple_check #(
        .msg_len    (MSG_LEN),
        .expected   (EXP),
        .hold_cycles(HOLD)
    ) dut (
        ._clock      (clk),
        ._reset      (rst),
        ._rx_in      (rx_in),
        ._rx_valid   (rx_valid),
        ._rx_ready   (rdy),
        ._match      (mtc),
        ._error      (err),
        ._match_count(mcnt),
        ._error_count(ecnt)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] exp_byte(input int k);
        logic [63:0] v;
        v = EXP;
        return v[8*k +: 8];
    endfunction

    function automatic bit m_ready();
        return m_live && (m_hold == 0);
    endfunction

    // One clock: drive inputs, let the edge pass, advance the model, sample at +1.
    task automatic step(input bit v, input logic [7:0] b);
        bit acc;
        rx_valid = v;
        rx_in    = b;
        acc      = v && m_ready();
        @(posedge clk);
        #1;
        m_match = 1'b0;
        m_error = 1'b0;
        if (m_hold > 0) begin
            m_hold--;
        end else if (acc) begin
            if (m_pos == 0) begin
                if (b == exp_byte(0)) m_pos = 1;
            end else if (b == exp_byte(m_pos)) begin
                m_pos++;
                if (m_pos == MSG_LEN) begin
                    m_pos   = 0;
                    m_match = 1'b1;
                    if (m_mcount < 65535) m_mcount++;
                    m_hold  = HOLD;
                end
            end else begin
                m_error = 1'b1;
                if (m_ecount < 65535) m_ecount++;
                m_pos = (b == exp_byte(0)) ? 1 : 0;
            end
        end
        m_live = 1'b1;
        rx_valid = 1'b0;
    endtask

    task automatic model_clear();
        m_pos = 0; m_hold = 0; m_mcount = 0; m_ecount = 0;
        m_live = 1'b0; m_match = 1'b0; m_error = 1'b0;
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        rst = 1'b1;
        #3;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        step(1'b0, 8'h00);
    endtask

    task automatic send_msg();
        for (int k = 0; k < MSG_LEN; k++) step(1'b1, exp_byte(k));
    endtask

    task automatic wait_hold();
        int guard = 0;
        while (!m_ready() && guard < 20) begin
            guard++;
            step(1'b0, 8'h00);
        end
    endtask

    task automatic test_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (rdy !== 1'b0)   begin n_fail++; $display("FAIL reset_ready: got %b want 0", rdy); end
        n_checks++; if (mtc !== 1'b0)   begin n_fail++; $display("FAIL reset_match: got %b want 0", mtc); end
        n_checks++; if (err !== 1'b0)   begin n_fail++; $display("FAIL reset_error: got %b want 0", err); end
        n_checks++; if (mcnt !== 16'd0) begin n_fail++; $display("FAIL reset_mcount: got %h want 0000", mcnt); end
        n_checks++; if (ecnt !== 16'd0) begin n_fail++; $display("FAIL reset_ecount: got %h want 0000", ecnt); end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        step(1'b0, 8'h00);
        n_checks++; if (rdy !== 1'b1)   begin n_fail++; $display("FAIL reset_ready_after_edge: got %b want 1", rdy); end
    endtask

    task automatic test_message();
        int lows = 0;
        do_reset();
        for (int k = 0; k < MSG_LEN; k++) begin
            step(1'b1, exp_byte(k));
            n_checks++;
            if (mtc !== ((k == MSG_LEN - 1) ? 1'b1 : 1'b0)) begin
                n_fail++; $display("FAIL msg_match_byte%0d: got %b want %b", k, mtc, k == MSG_LEN - 1);
            end
        end
        n_checks++; if (mcnt !== 16'd1) begin n_fail++; $display("FAIL msg_mcount: got %0d want 1", mcnt); end
        n_checks++; if (ecnt !== 16'd0) begin n_fail++; $display("FAIL msg_ecount: got %0d want 0", ecnt); end
        while (rdy !== 1'b1 && lows < 20) begin
            lows++;
            step(1'b0, 8'h00);
            if (lows == 1) begin
                n_checks++; if (mtc !== 1'b0) begin n_fail++; $display("FAIL msg_pulse_width: got %b want 0", mtc); end
            end
        end
        n_checks++; if (lows != HOLD) begin n_fail++; $display("FAIL msg_hold_len: got %0d want %0d", lows, HOLD); end
    endtask

    task automatic test_mismatch();
        logic [7:0] seq [3] = '{8'h70, 8'h69, 8'h41};
        do_reset();
        foreach (seq[i]) step(1'b1, seq[i]);
        n_checks++; if (err !== 1'b1)   begin n_fail++; $display("FAIL mis_error: got %b want 1", err); end
        n_checks++; if (ecnt !== 16'd1) begin n_fail++; $display("FAIL mis_ecount: got %0d want 1", ecnt); end
        n_checks++; if (mtc !== 1'b0)   begin n_fail++; $display("FAIL mis_match: got %b want 0", mtc); end
        step(1'b1, 8'h6E);
        n_checks++; if (err !== 1'b0)   begin n_fail++; $display("FAIL hunt_error: got %b want 0", err); end
        n_checks++; if (ecnt !== 16'd1) begin n_fail++; $display("FAIL hunt_ecount: got %0d want 1", ecnt); end
    endtask

    task automatic test_resync();
        logic [7:0] seq [8] = '{8'h70, 8'h69, 8'h70, 8'h69, 8'h6E, 8'h67, 8'h0D, 8'h0A};
        do_reset();
        foreach (seq[i]) begin
            step(1'b1, seq[i]);
            n_checks++;
            if (err !== ((i == 2) ? 1'b1 : 1'b0)) begin
                n_fail++; $display("FAIL resync_error_byte%0d: got %b want %b", i, err, i == 2);
            end
        end
        n_checks++; if (mtc !== 1'b1)   begin n_fail++; $display("FAIL resync_match: got %b want 1", mtc); end
        n_checks++; if (mcnt !== 16'd1) begin n_fail++; $display("FAIL resync_mcount: got %0d want 1", mcnt); end
        n_checks++; if (ecnt !== 16'd1) begin n_fail++; $display("FAIL resync_ecount: got %0d want 1", ecnt); end
    endtask

    task automatic test_hold_block();
        do_reset();
        send_msg();
        for (int i = 0; i < HOLD; i++) begin
            n_checks++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL hold_ready_c%0d: got %b want 0", i, rdy); end
            step(1'b1, 8'h70);
        end
        n_checks++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL hold_release: got %b want 1", rdy); end
        for (int k = 0; k < MSG_LEN; k++) step(1'b1, exp_byte(k));
        n_checks++; if (mtc !== 1'b1)   begin n_fail++; $display("FAIL hold_after_match: got %b want 1", mtc); end
        n_checks++; if (mcnt !== 16'd2) begin n_fail++; $display("FAIL hold_mcount: got %0d want 2", mcnt); end
        n_checks++; if (ecnt !== 16'd0) begin n_fail++; $display("FAIL hold_ecount: got %0d want 0", ecnt); end
    endtask

    task automatic test_reset_abort();
        do_reset();
        for (int k = 0; k < 3; k++) step(1'b1, exp_byte(k));
        do_reset();
        send_msg();
        n_checks++; if (mtc !== 1'b1)   begin n_fail++; $display("FAIL abort_match: got %b want 1", mtc); end
        n_checks++; if (mcnt !== 16'd1) begin n_fail++; $display("FAIL abort_mcount: got %0d want 1", mcnt); end
        n_checks++; if (ecnt !== 16'd0) begin n_fail++; $display("FAIL abort_ecount: got %0d want 0", ecnt); end
        step(1'b0, 8'h00);
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (mcnt !== 16'd0) begin n_fail++; $display("FAIL abort_hold_mcount: got %0d want 0", mcnt); end
        n_checks++; if (rdy !== 1'b0)   begin n_fail++; $display("FAIL abort_hold_ready: got %b want 0", rdy); end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        step(1'b0, 8'h00);
        n_checks++; if (rdy !== 1'b1)   begin n_fail++; $display("FAIL abort_ready_back: got %b want 1", rdy); end
    endtask

    task automatic test_random();
        bit         v;
        logic [7:0] b;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) < 7) b = exp_byte(m_pos);
            else if ($urandom_range(0, 1) == 0) b = exp_byte(0);
            else b = 8'($urandom_range(0, 255));
            step(v, b);
            n_checks++; if (rdy !== m_ready()) begin n_fail++; $display("FAIL rnd_ready@%0d: got %b want %b", i, rdy, m_ready()); end
            n_checks++; if (mtc !== m_match)   begin n_fail++; $display("FAIL rnd_match@%0d: got %b want %b", i, mtc, m_match); end
            n_checks++; if (err !== m_error)   begin n_fail++; $display("FAIL rnd_error@%0d: got %b want %b", i, err, m_error); end
            n_checks++; if (mcnt !== 16'(m_mcount)) begin n_fail++; $display("FAIL rnd_mcount@%0d: got %0d want %0d", i, mcnt, m_mcount); end
            n_checks++; if (ecnt !== 16'(m_ecount)) begin n_fail++; $display("FAIL rnd_ecount@%0d: got %0d want %0d", i, ecnt, m_ecount); end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        force dut.r_error_count = 16'hFFFE;
        @(negedge clk);
        release dut.r_error_count;
        m_ecount = 16'hFFFE;
        for (int r = 0; r < 2; r++) begin
            step(1'b1, 8'h70);
            step(1'b1, 8'h41);
            n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL sat_err_pulse%0d: got %b want 1", r, err); end
            n_checks++; if (ecnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_ecount%0d: got %h want FFFF", r, ecnt); end
        end
        send_msg();
        n_checks++; if (mcnt !== 16'd1) begin n_fail++; $display("FAIL sat_mcount_while_esat: got %0d want 1", mcnt); end
        wait_hold();
        force dut.r_match_count = 16'hFFFE;
        @(negedge clk);
        release dut.r_match_count;
        m_mcount = 16'hFFFE;
        for (int r = 0; r < 2; r++) begin
            send_msg();
            n_checks++; if (mtc !== 1'b1) begin n_fail++; $display("FAIL sat_match_pulse%0d: got %b want 1", r, mtc); end
            n_checks++; if (mcnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_mcount%0d: got %h want FFFF", r, mcnt); end
            wait_hold();
        end
        n_checks++; if (ecnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_ecount_final: got %h want FFFF", ecnt); end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_message();
        test_mismatch();
        test_resync();
        test_hold_block();
        test_reset_abort();
        test_random();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
